// File: rtl/play_time_counter_if.sv
// Control and display bundle between the player FSM / seven-segment path and the
// elapsed-playback timer.
interface play_time_counter_if;
   logic       play;
   logic       clear;
   logic [5:0] sec_units;
   logic [5:0] sec_tens;
   logic [5:0] min_units;
   logic [5:0] min_tens;
   logic       sec_tick;
   logic       overflow;

   modport master (
      output play, clear,
      input  sec_units, sec_tens, min_units, min_tens, sec_tick, overflow
   );

   modport slave (
      input  play, clear,
      output sec_units, sec_tens, min_units, min_tens, sec_tick, overflow
   );
endinterface

// File: rtl/play_time_counter.sv
// Elapsed-playback mm:ss timer (00:00..99:59) with a per-second prescaler. Its BCD
// digit outputs are six bits wide and feed the seven-segment decoders directly.
module play_time_counter #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   play_time_counter_if.slave   bus
);

   localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [3:0]       su_q, su_d;
   logic [3:0]       st_q, st_d;
   logic [3:0]       mu_q, mu_d;
   logic [3:0]       mt_q, mt_d;
   logic             tick_q, tick_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves one unassigned and infers a latch.
      pre_d  = pre_q;
      su_d   = su_q;
      st_d   = st_q;
      mu_d   = mu_q;
      mt_d   = mt_q;
      tick_d = 1'b0;
      ovf_d  = 1'b0;

      if (bus.clear) begin
         pre_d = '0;
         su_d  = '0;
         st_d  = '0;
         mu_d  = '0;
         mt_d  = '0;
      end else if (bus.play) begin
         if (pre_q == PRE_MAX) begin
            pre_d  = '0;
            tick_d = 1'b1;
            // Ripple the carry up through the four BCD digits.
            if (su_q == 4'd9) begin
               su_d = '0;
               if (st_q == 4'd5) begin
                  st_d = '0;
                  if (mu_q == 4'd9) begin
                     mu_d = '0;
                     if (mt_q == 4'd9) begin
                        mt_d  = '0;
                        ovf_d = 1'b1;
                     end else begin
                        mt_d = mt_q + 4'd1;
                     end
                  end else begin
                     mu_d = mu_q + 4'd1;
                  end
               end else begin
                  st_d = st_q + 4'd1;
               end
            end else begin
               su_d = su_q + 4'd1;
            end
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         su_q   <= '0;
         st_q   <= '0;
         mu_q   <= '0;
         mt_q   <= '0;
         tick_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         su_q   <= su_d;
         st_q   <= st_d;
         mu_q   <= mu_d;
         mt_q   <= mt_d;
         tick_q <= tick_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.sec_units = {2'b00, su_q};
   assign bus.sec_tens  = {2'b00, st_q};
   assign bus.min_units = {2'b00, mu_q};
   assign bus.min_tens  = {2'b00, mt_q};
   assign bus.sec_tick  = tick_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_play_time_counter.sv
// Directed bench for play_time_counter: a TICKS_PER_SEC=4 instance for the main
// scenarios and a TICKS_PER_SEC=1 instance for the degenerate prescaler.
module tb_play_time_counter;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_miss = 0;

   play_time_counter_if bus4 ();
   play_time_counter_if bus1 ();

   play_time_counter #(.TICKS_PER_SEC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   play_time_counter #(.TICKS_PER_SEC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Time packed as mm:ss nibbles, e.g. 03:27 -> 16'h0327.
   function automatic logic [15:0] t4();
      return {bus4.min_tens[3:0], bus4.min_units[3:0], bus4.sec_tens[3:0], bus4.sec_units[3:0]};
   endfunction

   function automatic logic [15:0] t1();
      return {bus1.min_tens[3:0], bus1.min_units[3:0], bus1.sec_tens[3:0], bus1.sec_units[3:0]};
   endfunction

   function automatic logic legal(input logic [5:0] su, input logic [5:0] st,
                                  input logic [5:0] mu, input logic [5:0] mt);
      return (su <= 6'd9) && (st <= 6'd5) && (mu <= 6'd9) && (mt <= 6'd9);
   endfunction

   // One rising edge, then sample 1 time unit later and check display legality.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check("disp4", 32'(legal(bus4.sec_units, bus4.sec_tens, bus4.min_units, bus4.min_tens)), 32'd1);
         check("disp1", 32'(legal(bus1.sec_units, bus1.sec_tens, bus1.min_units, bus1.min_tens)), 32'd1);
      end
   endtask

   // Edges until the next sec_tick on the 4-tick instance, bounded.
   task automatic edges_to_tick(input string tag, input int exp);
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (!bus4.sec_tick && n <= 16);
      check(tag, n, exp);
   endtask

   task automatic clear4();
      bus4.clear = 1'b1;
      step(1);
      bus4.clear = 1'b0;
   endtask

   initial begin
      bus4.play = 1'b0; bus4.clear = 1'b0;
      bus1.play = 1'b0; bus1.clear = 1'b0;

      // Power-on reset, applied between clock edges.
      #2 rst_n = 1'b0;
      #1;
      check("por_time", t4(), 16'h0000);
      check("por_pulses", {bus4.sec_tick, bus4.overflow}, 2'b00);
      #9 rst_n = 1'b1;

      // Reset mid-count at 03:27, asynchronously.
      bus4.play = 1'b1;
      step(828);
      check("at_0327", t4(), 16'h0327);
      check("tick_0327", bus4.sec_tick, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_time", t4(), 16'h0000);
      check("rst_pulses", {bus4.sec_tick, bus4.overflow}, 2'b00);
      #2 rst_n = 1'b1;
      edges_to_tick("rst_first_tick", 4);
      check("rst_after", t4(), 16'h0001);

      // Basic count: 40 edges, tick every 4th.
      bus4.play = 1'b0;
      clear4();
      check("clr_time", t4(), 16'h0000);
      bus4.play = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         step(1);
         check("basic_tick", bus4.sec_tick, (e % 4) == 0);
      end
      check("basic_time", t4(), 16'h0010);

      // Pause keeps the fractional second.
      bus4.play = 1'b0;
      clear4();
      bus4.play = 1'b1;
      step(2);
      check("pause_pre", bus4.sec_tick, 1'b0);
      bus4.play = 1'b0;
      for (int e = 0; e < 10; e++) begin
         step(1);
         check("pause_tick", bus4.sec_tick, 1'b0);
      end
      bus4.play = 1'b1;
      edges_to_tick("pause_resume", 2);
      check("pause_time", t4(), 16'h0001);

      // Play dropped on the edge where pre is at its maximum.
      step(3);
      check("drop_pre", bus4.sec_tick, 1'b0);
      bus4.play = 1'b0;
      step(2);
      check("drop_tick", bus4.sec_tick, 1'b0);
      check("drop_time", t4(), 16'h0001);
      bus4.play = 1'b1;
      step(1);
      check("drop_resume", bus4.sec_tick, 1'b1);
      check("drop_time2", t4(), 16'h0002);

      // Carry chain to 10:00, then wrap 99:59 -> 00:00.
      bus4.play = 1'b0;
      clear4();
      bus4.play = 1'b1;
      step(599 * 4);
      check("t_0959", t4(), 16'h0959);
      step(3);
      check("c1000_early", bus4.sec_tick, 1'b0);
      step(1);
      check("t_1000", t4(), 16'h1000);
      check("c1000_pulses", {bus4.sec_tick, bus4.overflow}, 2'b10);
      step(5399 * 4);
      check("t_9959", t4(), 16'h9959);
      check("ovf_early", bus4.overflow, 1'b0);
      step(4);
      check("t_wrap", t4(), 16'h0000);
      check("wrap_pulses", {bus4.sec_tick, bus4.overflow}, 2'b11);
      step(1);
      check("wrap_after", {bus4.sec_tick, bus4.overflow}, 2'b00);

      // Clear at 00:07 with pre==3, play held high.
      bus4.play = 1'b0;
      clear4();
      bus4.play = 1'b1;
      step(7 * 4 + 3);
      check("t_0007", t4(), 16'h0007);
      bus4.clear = 1'b1;
      step(1);
      check("clr_wins", t4(), 16'h0000);
      check("clr_pulses", {bus4.sec_tick, bus4.overflow}, 2'b00);
      bus4.clear = 1'b0;
      edges_to_tick("clr_next_tick", 4);
      check("clr_next_time", t4(), 16'h0001);

      // TICKS_PER_SEC=1: increments on every played edge.
      check("one_idle", t1(), 16'h0000);
      bus1.play = 1'b1;
      step(1);
      check("one_t1", t1(), 16'h0001);
      check("one_tick1", bus1.sec_tick, 1'b1);
      step(2);
      check("one_t3", t1(), 16'h0003);
      check("one_tick3", bus1.sec_tick, 1'b1);
      bus1.play = 1'b0;
      step(1);
      check("one_hold", t1(), 16'h0003);
      check("one_notick", bus1.sec_tick, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/play_time_counter.md
# play_time_counter

Elapsed-playback timer for the music player front panel. Counts mm:ss (00:00 to 99:59) while playback is active and presents four decimal digits, each 6 bits wide, ready to feed the four `driver7seg` digit decoders directly. Sits between the player control FSM, which supplies `play` and `clear`, and the seven-segment display path.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per counted second. Legal range is ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `play`  in  1  level; 1 = time advances, 0 = paused.
- `clear`  in  1  synchronous clear of time and prescaler.
- `sec_units`  out  6  seconds units digit, 0–9.
- `sec_tens`  out  6  seconds tens digit, 0–5.
- `min_units`  out  6  minutes units digit, 0–9.
- `min_tens`  out  6  minutes tens digit, 0–9.
- `sec_tick`  out  1  one-cycle pulse on every time increment.
- `overflow`  out  1  one-cycle pulse when 99:59 wraps to 00:00.

## Operation
- Prescaler `pre`:
  - Width is `$clog2(TICKS_PER_SEC)`, with a minimum of 1. Range is 0..TICKS_PER_SEC-1.
  - Advances by 1 on each edge with `play`=1.
  - Holds its value with `play`=0, so pause keeps the fractional second.
- Increment condition: `play`=1 and `pre`==TICKS_PER_SEC-1. On that edge:
  - `pre` goes to 0.
  - Time advances by one second.
  - `sec_tick`=1 for that cycle.
- Digit cascade, BCD per digit:
  - `sec_units` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 carries into `min_units`.
  - `min_units` 9→0 carries into `min_tens`.
  - `min_tens` 9→0 raises `overflow` for that cycle; time reads 00:00 and counting continues.
- Digit encoding: every digit output has bits [5:4] = 0. Values are binary 0–9, so each is directly a legal `driver7seg` `b` input.
- `clear`=1:
  - Has priority over `play`.
  - On that edge: `pre`, all digits, `sec_tick` and `overflow` go to 0.
  - No increment occurs, even if the increment condition also holds.
- Status pulses: `sec_tick` and `overflow` are 0 on every edge that does not meet their condition.
- TICKS_PER_SEC = 1: `pre` stays 0 and time increments on every edge with `play`=1.
- `play` dropped on the edge where `pre`==TICKS_PER_SEC-1: no increment. The increment happens on the first edge after `play` returns.

## Timing
- Reset (`rst_n`=0): asynchronously forces the following to 0 immediately, independent of `clk`, and holds them while `rst_n`=0:
  - `pre`
  - all digit outputs
  - `sec_tick`
  - `overflow`
- Reset mid-count: discards both the partial second and the accumulated time.
- All outputs are registered. No combinational path exists from inputs to outputs.
- From reset release or clear, with `play` held at 1: the first increment is visible after exactly TICKS_PER_SEC rising edges. Subsequent increments follow every TICKS_PER_SEC edges.
- Digits and `sec_tick` change on the same edge. `overflow` coincides with the `sec_tick` of the wrap.
- `clear` latency: 1 edge. Outputs read 00:00 after the edge on which `clear` is sampled high.

## Test plan
All scenarios use TICKS_PER_SEC = 4.
- **Reset:** drive `rst_n`=0 mid-count at time 03:27, asynchronously and without a clock edge.
  - Required: all digits 0 and both pulses 0 immediately.
  - Required: after `rst_n`=1 with `play`=1, `sec_tick` first asserts on edge 4.
- **Basic count:** `play`=1 for 40 edges from 00:00.
  - Required: `sec_tick` on edges 4, 8, …, 40.
  - Required: final digits min_tens=0, min_units=0, sec_tens=1, sec_units=0.
- **Pause:** `play`=1 for 2 edges, 0 for 10 edges, 1 again.
  - Required: no tick during the pause.
  - Required: first tick after exactly 2 more `play` edges; time 00:01.
- **Carry chain:** preload by counting to 09:59, then one more second.
  - Required: 10:00 with a single `sec_tick` and no `overflow`.
  - Then count to 99:59 and one more second. Required: 00:00, with `overflow` and `sec_tick` both high for exactly that one cycle.
- **Clear:** at time 00:07 with `pre`==3, assert `clear`=1 together with `play`=1.
  - Required: next state is 00:00 with `pre`=0 and no `sec_tick`.
  - Required: the next tick arrives 4 edges after `clear` deasserts.
- **Display compatibility:** on every cycle of the above scenarios, each digit has bits [5:4]==0 and value ≤9, and `sec_tens` ≤5.
